// File: rtl/hk_spi_responder.sv
// rtl/hk_spi_responder.sv - SPI mode-0 responder driving an 8-bit register bus; HKSPI_ID_EN adds the 8'h9F ID stream.
module hk_spi_responder #(
    parameter logic [15:0] ID_WORD = 16'h1405
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       csb,
    input  logic       sck,
    input  logic       sdi,
    output logic       sdo,
    output logic       sdo_oeb,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMMAND,
        S_ADDRESS,
        S_DATA,
        S_IGNORE
    } state_t;

    state_t      r_state;
    logic [1:0]  r_csb_s;
    logic [1:0]  r_sck_s;
    logic [1:0]  r_sdi_s;
    logic        r_csb_d;
    logic        r_sck_d;
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_shift_in;
    logic [7:0]  r_shift_out;
    logic        r_rd;
    logic        r_wr;
    logic        r_load;
    logic        r_byte_done;

    logic        w_csb_fall;
    logic        w_csb_rise;
    logic        w_sck_rise;
    logic        w_sck_fall;
    logic        w_byte_end;
    logic [7:0]  w_byte;

`ifdef HKSPI_ID_EN
    logic        r_id;
    logic [15:0] r_id_shift;
`else
    logic        w_unused_id;
    assign w_unused_id = ^ID_WORD;
`endif

    // csb flops reset low so a csb held low through reset never looks like a fresh fall
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_csb_s <= 2'b00;
            r_sck_s <= 2'b00;
            r_sdi_s <= 2'b00;
            r_csb_d <= 1'b0;
            r_sck_d <= 1'b0;
        end else begin
            r_csb_s <= {r_csb_s[0], csb};
            r_sck_s <= {r_sck_s[0], sck};
            r_sdi_s <= {r_sdi_s[0], sdi};
            r_csb_d <= r_csb_s[1];
            r_sck_d <= r_sck_s[1];
        end
    end

    assign w_csb_fall = ~r_csb_s[1] &  r_csb_d;
    assign w_csb_rise =  r_csb_s[1] & ~r_csb_d;
    assign w_sck_rise =  r_sck_s[1] & ~r_sck_d;
    assign w_sck_fall = ~r_sck_s[1] &  r_sck_d;
    assign w_byte_end = w_sck_rise && (r_bit_cnt == 3'd7);
    assign w_byte     = {r_shift_in, r_sdi_s[1]};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift_in  <= 7'd0;
            r_shift_out <= 8'd0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_load      <= 1'b0;
            r_byte_done <= 1'b0;
            sdo         <= 1'b0;
            sdo_oeb     <= 1'b1;
            reg_addr    <= 8'd0;
            reg_wdata   <= 8'd0;
            reg_we      <= 1'b0;
            reg_re      <= 1'b0;
`ifdef HKSPI_ID_EN
            r_id        <= 1'b0;
            r_id_shift  <= 16'd0;
`endif
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            r_load <= reg_re;
            if (r_load) begin
                r_shift_out <= reg_rdata;
            end
            if (w_sck_rise) begin
                r_shift_in <= w_byte[6:0];
                r_bit_cnt  <= r_bit_cnt + 3'd1;
            end

            if (w_csb_rise) begin
                r_state     <= S_IDLE;
                r_rd        <= 1'b0;
                r_wr        <= 1'b0;
                r_byte_done <= 1'b0;
                sdo         <= 1'b0;
                sdo_oeb     <= 1'b1;
`ifdef HKSPI_ID_EN
                r_id        <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_csb_fall) begin
                            r_state   <= S_COMMAND;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    S_COMMAND: begin
                        if (w_byte_end) begin
                            case (w_byte)
                                8'h80: begin r_wr <= 1'b1; r_state <= S_ADDRESS; end
                                8'h40: begin r_rd <= 1'b1; r_state <= S_ADDRESS; end
                                8'hC0: begin r_wr <= 1'b1; r_rd <= 1'b1; r_state <= S_ADDRESS; end
`ifdef HKSPI_ID_EN
                                8'h9F: begin
                                    r_id       <= 1'b1;
                                    r_id_shift <= ID_WORD;
                                    sdo_oeb    <= 1'b0;
                                    r_state    <= S_DATA;
                                end
`endif
                                default: r_state <= S_IGNORE;
                            endcase
                        end
                    end
                    S_ADDRESS: begin
                        if (w_byte_end) begin
                            reg_addr <= w_byte;
                            reg_re   <= r_rd;
                            sdo_oeb  <= ~r_rd;
                            r_state  <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (w_sck_fall && r_rd) begin
                            sdo         <= r_shift_out[7];
                            r_shift_out <= {r_shift_out[6:0], 1'b0};
                        end
`ifdef HKSPI_ID_EN
                        if (w_sck_fall && r_id) begin
                            sdo        <= r_id_shift[15];
                            r_id_shift <= {r_id_shift[14:0], r_id_shift[15]};
                        end
`endif
                        if (w_byte_end && r_wr) begin
                            reg_wdata <= w_byte;
                            reg_we    <= 1'b1;
                        end
                        if (w_byte_end && (r_rd || r_wr)) begin
                            r_byte_done <= 1'b1;
                        end
                        // increment a cycle late so reg_we sees byte N's address and reg_re sees N+1
                        if (r_byte_done) begin
                            r_byte_done <= 1'b0;
                            reg_addr    <= reg_addr + 8'd1;
                            reg_re      <= r_rd;
                        end
                    end
                    S_IGNORE: begin
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hk_spi_responder.sv
// tb/tb_hk_spi_responder.sv - directed and randomized transactions against a transaction-level model of hk_spi_responder.
module tb_hk_spi_responder;

    localparam int HP = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       csb;
    logic       sck;
    logic       sdi;
    logic       sdo;
    logic       sdo_oeb;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'd0;

    always #5 clk = ~clk;

    hk_spi_responder #(.ID_WORD(16'h1405)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .csb      (csb),
        .sck      (sck),
        .sdi      (sdi),
        .sdo      (sdo),
        .sdo_oeb  (sdo_oeb),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .reg_rdata(reg_rdata)
    );

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    logic [7:0]  mem [0:255];
    logic [7:0]  we_a[$];
    logic [7:0]  we_d[$];
    logic [7:0]  re_a[$];
    int unsigned we_t[$];
    int unsigned re_t[$];
    int          overlap = 0;
    int          oeb_low = 0;
    logic [7:0]  tx [0:7];
    logic [7:0]  rx [0:7];

    // register-bus responder and strobe log
    always @(negedge clk) begin
        cyc++;
        if (reg_we) begin
            we_a.push_back(reg_addr);
            we_d.push_back(reg_wdata);
            we_t.push_back(cyc);
        end
        if (reg_re) begin
            re_a.push_back(reg_addr);
            re_t.push_back(cyc);
            reg_rdata = mem[reg_addr];
        end
        if (reg_we && reg_re) overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        we_a.delete(); we_d.delete(); we_t.delete();
        re_a.delete(); re_t.delete();
        overlap = 0;
        oeb_low = 0;
    endtask

    task automatic spi_bit(input logic b, output logic r);
        sdi = b;
        repeat (HP) @(negedge clk);
        r = sdo;
        if (!sdo_oeb) oeb_low++;
        sck = 1'b1;
        repeat (HP) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        logic t;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(b[i], t);
            r[i] = t;
        end
    endtask

    // cmd, then tx[0] (address position), nd data bytes, extra trailing bits
    task automatic xfer(input logic [7:0] cmd, input int nd, input int extra);
        logic [7:0] r;
        logic       t;
        clear_log();
        csb = 1'b0;
        repeat (HP) @(negedge clk);
        spi_byte(cmd, r);
        for (int k = 0; k <= nd; k++) begin
            spi_byte(tx[k], r);
            rx[k] = r;
        end
        for (int k = 0; k < extra; k++) spi_bit(1'($urandom_range(0, 1)), t);
        repeat (HP) @(negedge clk);
        csb = 1'b1;
        repeat (4 * HP) @(negedge clk);
    endtask

    task automatic check_xfer(input string tag, input logic [7:0] cmd, input int nd, input int extra);
        bit         is_wr;
        bit         is_rd;
        int         ew;
        int         er;
        logic [7:0] ea;
        is_wr = (cmd == 8'h80) || (cmd == 8'hC0);
        is_rd = (cmd == 8'h40) || (cmd == 8'hC0);
        ew = is_wr ? nd : 0;
        er = is_rd ? nd + 1 : 0;
        chk($sformatf("%s we_count", tag), we_a.size(), ew);
        for (int i = 0; i < ew && i < we_a.size(); i++) begin
            ea = tx[0] + 8'(i);
            chk($sformatf("%s we_addr[%0d]", tag, i), we_a[i], ea);
            chk($sformatf("%s we_data[%0d]", tag, i), we_d[i], tx[i+1]);
        end
        chk($sformatf("%s re_count", tag), re_a.size(), er);
        for (int i = 0; i < er && i < re_a.size(); i++) begin
            ea = tx[0] + 8'(i);
            chk($sformatf("%s re_addr[%0d]", tag, i), re_a[i], ea);
        end
        if (is_rd) begin
            for (int i = 0; i < nd; i++) begin
                ea = tx[0] + 8'(i);
                chk($sformatf("%s sdo_byte[%0d]", tag, i), rx[i+1], mem[ea]);
            end
        end
        if (is_rd && is_wr) begin
            for (int i = 0; i < nd && i < we_t.size() && i + 1 < re_t.size(); i++)
                chk($sformatf("%s we_before_re[%0d]", tag, i), re_t[i+1] > we_t[i], 1);
        end
        chk($sformatf("%s oeb_low_bits", tag), oeb_low, is_rd ? nd * 8 + extra : 0);
        chk($sformatf("%s we_re_overlap", tag), overlap, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk($sformatf("%s sdo", tag), sdo, 0);
        chk($sformatf("%s sdo_oeb", tag), sdo_oeb, 1);
        chk($sformatf("%s reg_addr", tag), reg_addr, 0);
        chk($sformatf("%s reg_wdata", tag), reg_wdata, 0);
        chk($sformatf("%s reg_we", tag), reg_we, 0);
        chk($sformatf("%s reg_re", tag), reg_re, 0);
    endtask

    initial begin
        logic [7:0]  cmd;
        logic [7:0]  r;
        logic        t;
        logic [15:0] idw;
        int          nd;
        int          extra;

        rst = 1'b1; csb = 1'b1; sck = 1'b0; sdi = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // two-byte write
        tx[0] = 8'h12; tx[1] = 8'hA5; tx[2] = 8'h3C;
        xfer(8'h80, 2, 0);
        check_xfer("write_12", 8'h80, 2, 0);

        // read across the address wrap
        mem[8'hFF] = 8'h5A; mem[8'h00] = 8'hC3;
        tx[0] = 8'hFF; tx[1] = 8'h00; tx[2] = 8'h00;
        xfer(8'h40, 2, 0);
        check_xfer("read_ff", 8'h40, 2, 0);

        // unsupported command
        tx[0] = 8'h55; tx[1] = 8'hAA;
        xfer(8'h21, 1, 0);
        check_xfer("ignore_21", 8'h21, 1, 0);

        // partial data byte is dropped, next write decodes normally
        tx[0] = 8'h30;
        xfer(8'h80, 0, 5);
        check_xfer("partial_wr", 8'h80, 0, 5);
        tx[0] = 8'h40; tx[1] = 8'h99;
        xfer(8'h80, 1, 0);
        check_xfer("after_partial", 8'h80, 1, 0);

        // reset during the address byte
        clear_log();
        csb = 1'b0;
        repeat (HP) @(negedge clk);
        spi_byte(8'hC0, r);
        for (int k = 0; k < 4; k++) spi_bit(1'b1, t);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        for (int k = 0; k < 20; k++) spi_bit(1'($urandom_range(0, 1)), t);
        repeat (HP) @(negedge clk);
        chk("mid_reset we_count", we_a.size(), 0);
        chk("mid_reset re_count", re_a.size(), 0);
        chk("mid_reset oeb_low", oeb_low, 0);
        csb = 1'b1;
        repeat (4 * HP) @(negedge clk);
        tx[0] = 8'h7E; tx[1] = 8'h11; tx[2] = 8'h22;
        xfer(8'hC0, 2, 0);
        check_xfer("after_reset_rw", 8'hC0, 2, 0);

        // identity command
        tx[0] = 8'h00; tx[1] = 8'h00; tx[2] = 8'h00; tx[3] = 8'h00;
        xfer(8'h9F, 3, 0);
        chk("id we_count", we_a.size(), 0);
        chk("id re_count", re_a.size(), 0);
`ifdef HKSPI_ID_EN
        idw = 16'h1405;
        chk("id byte0", rx[0], idw[15:8]);
        chk("id byte1", rx[1], idw[7:0]);
        chk("id byte2", rx[2], idw[15:8]);
        chk("id byte3", rx[3], idw[7:0]);
        chk("id oeb_low", oeb_low, 32);
`else
        idw = 16'h0000;
        chk("id oeb_low", oeb_low, 0);
        chk("id idle_sdo", sdo, idw[0]);
`endif

        // randomized transactions
        for (int n = 0; n < 20; n++) begin
            case ($urandom_range(0, 3))
                0: cmd = 8'h80;
                1: cmd = 8'h40;
                2: cmd = 8'hC0;
                default: begin
                    do cmd = 8'($urandom);
                    while (cmd == 8'h80 || cmd == 8'h40 || cmd == 8'hC0 || cmd == 8'h9F);
                end
            endcase
            nd    = $urandom_range(0, 3);
            extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            for (int k = 0; k < 8; k++) tx[k] = 8'($urandom);
            xfer(cmd, nd, extra);
            check_xfer($sformatf("rand%0d_cmd%02h", n, cmd), cmd, nd, extra);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hk_spi_responder.md
HK_SPI_RESPONDER -- requirements
Module: hk_spi_responder

Interface
REQ-001 Parameter ID_WORD, default 16'h1405, 2-byte identity returned by the ID command.
REQ-002 wb_clk_i  input  1  sole clock; all logic is on its rising edge.
REQ-003 wb_rst_i  input  1  reset, synchronous, active-high.
REQ-004 csb  input  1  SPI chip select from pad, active-low, asynchronous to wb_clk_i.
REQ-005 sck  input  1  SPI clock from pad, asynchronous to wb_clk_i.
REQ-006 sdi  input  1  SPI serial data in (host to block).
REQ-007 sdo  output  1  SPI serial data out (block to host).
REQ-008 sdo_oeb  output  1  pad output enable for sdo, active-low.
REQ-009 reg_addr  output  8  register address.
REQ-010 reg_wdata  output  8  write data.
REQ-011 reg_we  output  1  one-cycle write strobe.
REQ-012 reg_re  output  1  one-cycle read strobe.
REQ-013 reg_rdata  input  8  read data; valid in the cycle after reg_re.

Function
REQ-014 csb, sck and sdi SHALL each pass through a 2-flop synchronizer; sck edges SHALL be detected from the synchronized value, giving a fixed 3-cycle input latency.
REQ-015 wb_clk_i SHALL be at least 8x the sck frequency; slower ratios are unsupported.
REQ-016 SPI mode 0, MSB first: sdi SHALL be sampled on sck rise, sdo SHALL change on sck fall.
REQ-017 States SHALL be IDLE, COMMAND, ADDRESS, DATA, IGNORE.
REQ-018 IDLE -> COMMAND on a synchronized csb falling edge; the bit counter SHALL clear to 0.
REQ-019 COMMAND -> ADDRESS after 8 bits if the command is 8'h80 (write), 8'h40 (read) or 8'hC0 (read+write).
REQ-020 Any other command SHALL enter IGNORE: no strobes, sdo_oeb held 1 until csb rises.
REQ-021 ADDRESS -> DATA after 8 bits; reg_addr SHALL load the received byte.
REQ-022 For read commands, reg_re SHALL pulse in the cycle after the 8th address bit and after every completed data byte, following the address increment.
REQ-023 reg_rdata SHALL load the shift-out register one cycle after reg_re; its MSB SHALL drive sdo from the next sck fall.
REQ-024 sdo_oeb SHALL be 0 in DATA for read commands and 1 in all other states and commands.
REQ-025 For write commands, reg_wdata SHALL update and reg_we SHALL pulse one cycle after the 8th bit of each data byte is sampled.
REQ-026 reg_addr SHALL increment after each completed data byte, wrapping 8'hFF -> 8'h00.
REQ-027 For 8'hC0, reg_we for byte N SHALL precede reg_re for address N+1 by at least one cycle.
REQ-028 A synchronized csb rise SHALL return the state to IDLE in that cycle from any state; a partial byte SHALL be discarded and generate no strobe.
REQ-029 reg_we and reg_re SHALL never be asserted in the same cycle.

Reset
REQ-030 Under wb_rst_i: state IDLE, sdo=0, sdo_oeb=1, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, bit counter 0.
REQ-031 Reset asserted mid-transaction SHALL abort it; the block SHALL stay in IDLE until csb is seen high and then falls again.

Configuration
REQ-032 With macro HKSPI_ID_EN defined, command 8'h9F SHALL skip ADDRESS and stream ID_WORD MSB-first, then repeat, with sdo_oeb=0 and no reg_re.
REQ-033 Without HKSPI_ID_EN, 8'h9F SHALL be treated as an unsupported command (IGNORE), and no ID logic SHALL be synthesized.

Verification
REQ-034 Write 8'h80, 8'h12, 8'hA5, 8'h3C -> reg_we pulses twice: (addr 8'h12, data 8'hA5), then (8'h13, 8'h3C).
REQ-035 Read 8'h40, 8'hFF with reg_rdata=8'h5A then 8'hC3, 16 sck -> reg_re at addr 8'hFF then 8'h00; sdo shifts 8'h5A then 8'hC3.
REQ-036 Command 8'h21 followed by 16 sck -> no strobes, sdo_oeb stays 1, state IDLE after csb rise.
REQ-037 csb rises after 5 data bits of a write -> no reg_we; the next transaction decodes normally.
REQ-038 wb_rst_i pulsed during the address byte -> outputs at reset values; no strobes until a fresh csb fall.
REQ-039 HKSPI_ID_EN defined, command 8'h9F, 32 sck -> sdo 8'h14, 8'h05, 8'h14, 8'h05; undefined -> sdo_oeb stays 1.
